fsic_is_rx_fifo: RTL and testbench
==================================

// Module: fsic_is_rx_fifo
// PURPOSE
//  Receive buffer between the IO serdes RX outputs (is_as_*) and the axis switch: is_as_tvalid carries no backpressure, so
//  every beat is captured. Head of FIFO drives an AXIS master (m_*) with tready. Drives as_is_tready back into the serdes
//  TX path as the flow-control bit to the remote side: low when free space <= pTHRESHOLD, so in-flight beats cannot overflow.
// PARAMETERS
//  pDATA_WIDTH  32  tdata width; tstrb/tkeep are pDATA_WIDTH/8
//  pDEPTH       8   FIFO entries, >=4, any integer (not required to be power of 2)
//  pTHRESHOLD   3   free-entry reserve; must cover remote serdes round-trip, <pDEPTH
// PORTS
//  axis_clk       in   1     core clock (single clock domain)
//  axis_rst_n     in   1     synchronous active-low reset
//  is_as_tdata    in   pDATA_WIDTH     beat data from serdes RX
//  is_as_tstrb    in   pDATA_WIDTH/8
//  is_as_tkeep    in   pDATA_WIDTH/8
//  is_as_tlast    in   1
//  is_as_tid      in   2
//  is_as_tuser    in   2
//  is_as_tvalid   in   1     beat present; captured unconditionally (no ready)
//  m_tdata/m_tstrb/m_tkeep/m_tlast/m_tid/m_tuser  out  same widths  head-entry fields
//  m_tvalid       out  1     FIFO not empty
//  m_tready       in   1     downstream accepts head
//  as_is_tready   out  1     flow control to remote (via serdes TX)
//  fifo_level     out  $clog2(pDEPTH+1)  current occupancy
//  overflow       out  1     sticky: a beat was dropped while full
//  overflow_clr   in   1     clears overflow
// BEHAVIOUR
//  Reset (sync, axis_rst_n=0 at posedge): wr_ptr=rd_ptr=0, level=0, m_tvalid=0, as_is_tready=0, overflow=0; storage not reset.
//  Entry = {tuser,tid,tlast,tkeep,tstrb,tdata}, 2+2+1+pDATA_WIDTH/8*2+pDATA_WIDTH bits (45 at default), stored/returned intact.
//  push = is_as_tvalid && (level<pDEPTH || pop); pop = m_tvalid && m_tready.
//  First-word-fall-through: m_* = mem[rd_ptr] combinationally; m_tvalid = (level!=0). Write-to-m_tvalid latency 1 cycle.
//  Stable head: while m_tvalid && !m_tready, m_* must not change.
//  Pointers increment on push/pop; wrap pDEPTH-1 -> 0 explicitly.
//  level_next = level + push - pop; simultaneous push+pop keeps level; push+pop when full is legal (no drop).
//  Push while empty + m_tready same cycle: not popped (m_tvalid was 0); beat appears next cycle.
//  Drop: is_as_tvalid && level==pDEPTH && !pop -> beat discarded, pointers unchanged, overflow<=1 at that edge.
//  overflow: set has priority over overflow_clr in the same cycle; otherwise clr -> 0.
//  as_is_tready registered: <= ((pDEPTH - level_next) > pTHRESHOLD); reflects the level produced by the same edge.
//  Default: tready=1 for level_next<=4, 0 for level_next>=5. No hysteresis.
//  First edge after reset release with empty FIFO: as_is_tready -> 1.
//  Reset mid-operation: contents discarded, m_tvalid 0 at the reset edge, as_is_tready 0 until first edge with reset released.
//  is_as_tdata etc. ignored when is_as_tvalid=0; X on them must not propagate into state.
// TESTING
//  1 Reset release, idle -> cycle1: as_is_tready=1, m_tvalid=0, fifo_level=0, overflow=0.
//  2 m_tready=0, 5 beats tdata 0x11..0x55 -> level=5, as_is_tready falls at 5th edge; m_tdata=0x11 held stable.
//  3 Continue to 9 beats, m_tready=0 -> level=8, 9th dropped, overflow=1; clr -> 0; drain yields 0x11..0x88 in order, tlast/tid/tuser intact.
//  4 Full FIFO, is_as_tvalid & m_tready same cycle for 20 cycles -> level stays 8, no overflow, order preserved across pointer wrap.
//  5 Random valid(70%)/ready(50%) 10k beats vs scoreboard -> zero mismatch; drops only while level==8 without pop.
//  6 Assert reset with level=6 mid-stream -> next edge level=0, m_tvalid=0, as_is_tready=0; after release as_is_tready=1, old data never emitted.

Source files
------------

// File: rtl/fsic_is_rx_fifo.sv
// Receive FIFO between the serdes RX beat stream and the AXIS switch. It captures every beat
// and presents the head first-word-fall-through. as_is_tready throttles the remote transmitter.
module fsic_is_rx_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8,
  parameter int pTHRESHOLD  = 3
) (
  input  logic                         axis_clk,
  input  logic                         axis_rst_n,
  input  logic [pDATA_WIDTH-1:0]       is_as_tdata,
  input  logic [pDATA_WIDTH/8-1:0]     is_as_tstrb,
  input  logic [pDATA_WIDTH/8-1:0]     is_as_tkeep,
  input  logic                         is_as_tlast,
  input  logic [1:0]                   is_as_tid,
  input  logic [1:0]                   is_as_tuser,
  input  logic                         is_as_tvalid,
  output logic [pDATA_WIDTH-1:0]       m_tdata,
  output logic [pDATA_WIDTH/8-1:0]     m_tstrb,
  output logic [pDATA_WIDTH/8-1:0]     m_tkeep,
  output logic                         m_tlast,
  output logic [1:0]                   m_tid,
  output logic [1:0]                   m_tuser,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         as_is_tready,
  output logic [$clog2(pDEPTH+1)-1:0]  fifo_level,
  output logic                         overflow,
  input  logic                         overflow_clr
);

  localparam int STRB_W  = pDATA_WIDTH / 8;
  localparam int ENTRY_W = 5 + 2 * STRB_W + pDATA_WIDTH;
  localparam int PTR_W   = $clog2(pDEPTH);
  localparam int LVL_W   = $clog2(pDEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(pDEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(pDEPTH);
  // Occupancy at or above this leaves no more than pTHRESHOLD free entries.
  localparam logic [LVL_W-1:0] LVL_THROT = LVL_W'(pDEPTH - pTHRESHOLD);

  logic [ENTRY_W-1:0] r_mem [pDEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_overflow;
  logic               r_tready;

  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [LVL_W-1:0]   w_level_next;
  logic [ENTRY_W-1:0] w_wr_entry;

  assign w_pop        = (r_level != '0) && m_tready;
  assign w_push       = is_as_tvalid && ((r_level != LVL_FULL) || w_pop);
  assign w_drop       = is_as_tvalid && (r_level == LVL_FULL) && !w_pop;
  assign w_level_next = r_level + {{(LVL_W-1){1'b0}}, w_push} - {{(LVL_W-1){1'b0}}, w_pop};
  assign w_wr_entry   = {is_as_tuser, is_as_tid, is_as_tlast, is_as_tkeep, is_as_tstrb, is_as_tdata};

  // Storage is written only on an accepted beat, so idle-bus X never reaches it.
  always_ff @(posedge axis_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_tready   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      r_level  <= w_level_next;
      r_tready <= (w_level_next < LVL_THROT);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign {m_tuser, m_tid, m_tlast, m_tkeep, m_tstrb, m_tdata} = r_mem[r_rd_ptr];
  assign m_tvalid     = (r_level != '0);
  assign fifo_level   = r_level;
  assign overflow     = r_overflow;
  assign as_is_tready = r_tready;

endmodule

// File: tb/tb_fsic_is_rx_fifo.sv
// Bench for fsic_is_rx_fifo: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, and a long randomized valid/ready run.
module tb_fsic_is_rx_fifo;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 8;
  localparam int THR   = 3;
  localparam int EW    = 5 + 2 * SW + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_strb, in_keep;
  logic          in_last;
  logic [1:0]    in_id, in_user;
  logic          in_valid;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb, m_tkeep;
  logic          m_tlast;
  logic [1:0]    m_tid, m_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic          as_is_tready;
  logic [3:0]    fifo_level;
  logic          overflow;
  logic          overflow_clr;

  fsic_is_rx_fifo #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pTHRESHOLD(THR)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .is_as_tdata(in_data), .is_as_tstrb(in_strb), .is_as_tkeep(in_keep),
    .is_as_tlast(in_last), .is_as_tid(in_id), .is_as_tuser(in_user), .is_as_tvalid(in_valid),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tid(m_tid), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .as_is_tready(as_is_tready), .fifo_level(fifo_level),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain queue of whole beats plus the two status flags.
  logic [EW-1:0] q[$];
  bit            e_ovf;
  bit            e_trdy;
  bit            model_on = 0;
  int            n_drops  = 0;

  always @(posedge clk) begin
    bit pop, was_full;
    if (!rst_n) begin
      q.delete();
      e_ovf    = 0;
      e_trdy   = 0;
      model_on = 1;
    end else if (model_on) begin
      was_full = (q.size() == DEPTH);
      pop      = (q.size() != 0) && m_tready;
      if (pop) void'(q.pop_front());
      if (in_valid && was_full && !pop) begin
        e_ovf = 1;
        n_drops++;
      end else begin
        if (in_valid) q.push_back({in_user, in_id, in_last, in_keep, in_strb, in_data});
        if (overflow_clr) e_ovf = 0;
      end
      e_trdy = (DEPTH - q.size()) > THR;
    end
  end

  always @(negedge clk) begin
    logic [EW-1:0] head;
    bit ok;
    if (model_on) begin
      head = {m_tuser, m_tid, m_tlast, m_tkeep, m_tstrb, m_tdata};
      ok = (int'(fifo_level) == q.size()) && (m_tvalid == (q.size() != 0)) &&
           (as_is_tready == e_trdy) && (overflow == e_ovf) &&
           (q.size() == 0 || head == q[0]);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL model t=%0t: level=%0d tvalid=%0b trdy=%0b ovf=%0b head=%h, required level=%0d trdy=%0b ovf=%0b head=%h",
                 $time, fifo_level, m_tvalid, as_is_tready, overflow, head,
                 q.size(), e_trdy, e_ovf, (q.size() != 0) ? q[0] : '0);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Inputs change at the falling edge, half a period away from the capturing edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input int i, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    in_strb  = 4'hF;
    in_keep  = SW'(i + 3);
    in_last  = i[0];
    in_id    = i[1:0];
    in_user  = 2'(i + 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_strb  = 4'(($urandom));
    in_keep  = 4'(($urandom));
    in_last  = 1'($urandom);
    in_id    = 2'($urandom);
    in_user  = 2'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; m_tready = 1'b0; overflow_clr = 1'b0;
    idle();
    repeat (3) tick();

    // Reset release while idle.
    rst_n = 1'b1;
    tick();
    chk("rst_trdy", 64'(as_is_tready), 64'd1);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // Five beats with no consumer: throttle drops on the fifth.
    for (int i = 0; i < 5; i++) begin
      beat(i, DW'(32'h11 * (i + 1)));
      tick();
      if (i == 3) chk("lvl4_trdy", 64'(as_is_tready), 64'd1);
    end
    idle();
    chk("lvl5_level", 64'(fifo_level), 64'd5);
    chk("lvl5_trdy", 64'(as_is_tready), 64'd0);
    chk("lvl5_head", 64'(m_tdata), 64'h11);

    // Four more: fill to 8, ninth dropped.
    for (int i = 5; i < 9; i++) begin
      beat(i, DW'(32'h11 * (i + 1)));
      tick();
    end
    idle();
    chk("full_level", 64'(fifo_level), 64'd8);
    chk("full_ovf", 64'(overflow), 64'd1);
    chk("full_head", 64'(m_tdata), 64'h11);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);

    // Drain and check order and sideband fields against literals.
    m_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_data", 64'(m_tdata), 64'(32'h11 * (k + 1)));
      chk("drain_side", 64'({m_tuser, m_tid, m_tlast}), 64'({2'(k + 1), 2'(k), 1'(k)}));
      tick();
    end
    chk("drained_tvalid", 64'(m_tvalid), 64'd0);

    // Full FIFO with simultaneous push and pop across pointer wrap.
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(i, DW'(32'h100 + i));
      tick();
    end
    m_tready = 1'b1;
    for (int i = 8; i < 28; i++) begin
      beat(i, DW'(32'h100 + i));
      tick();
    end
    idle();
    chk("wrap_level", 64'(fifo_level), 64'd8);
    chk("wrap_ovf", 64'(overflow), 64'd0);
    chk("wrap_head", 64'(m_tdata), 64'h114);
    repeat (10) tick();

    // Randomized traffic: 70% valid, 50% ready, occasional overflow clear.
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(99) < 70) beat(int'($urandom), $urandom);
      else idle();
      m_tready     = ($urandom_range(99) < 50);
      overflow_clr = ($urandom_range(63) == 0);
      tick();
    end
    idle();
    overflow_clr = 1'b0;
    n_tests++;
    if (n_drops == 0) begin
      n_fail++;
      $display("FAIL rand_drops: got %0d drops, required > 0", n_drops);
    end

    // Reset with six entries pending.
    m_tready = 1'b1;
    repeat (10) tick();
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      beat(i, DW'(32'hDEAD0000 + i));
      tick();
    end
    idle();
    chk("pre_rst_level", 64'(fifo_level), 64'd6);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_trdy", 64'(as_is_tready), 64'd0);
    rst_n = 1'b1;
    m_tready = 1'b1;
    tick();
    chk("post_rst_trdy", 64'(as_is_tready), 64'd1);
    chk("post_rst_tvalid", 64'(m_tvalid), 64'd0);
    repeat (5) tick();
    m_tready = 1'b0;
    beat(1, DW'(32'h0ABC));
    tick();
    idle();
    chk("post_rst_head", 64'(m_tdata), 64'hABC);
    chk("post_rst_level", 64'(fifo_level), 64'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
